// File: rtl/tt_mem_pkg.sv
// Shared definitions for the tile's 64x8 byte memory paths (serial capture/write
// and serial read-out).
//   TT_ADDR_W        : default memory address width (64 locations)
//   TT_DATA_W        : default memory word width (bits per serial byte)
//   BURST_LEN_OFFSET : burst_len fields encode (bytes - BURST_LEN_OFFSET)
//   state_e          : read-out engine FSM states
package tt_mem_pkg;

  localparam int TT_ADDR_W = 6;
  localparam int TT_DATA_W = 8;

  // A burst_len of 0 means one byte, so the byte count is len + 1.
  localparam int BURST_LEN_OFFSET = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/tt_piso_shifter.sv
// Parallel-in, serial-out shift register, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset (clears the register)
//   load       : capture din (has priority over shift)
//   shift      : shift left by one, zero-filling the LSB
//   din        : parallel load data
//   msb        : current MSB, i.e. the bit presented on the serial line
module tt_piso_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {sr_q[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = sr_q[DATA_W-1];

endmodule

// File: rtl/tt_serial_mem_reader.sv
// Serial read-out engine for the tile's byte memory. On start it fetches one or
// more consecutive bytes through a 1-cycle-latency synchronous read port and
// streams them MSB first, gaplessly, on a single serial pin.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : start request (accepted in IDLE and DONE only)
//   start_addr_i : first byte address, captured with start_i
//   burst_len_i  : bytes to send minus 1, captured with start_i
//   mem_rd_o     : memory read strobe (decoded from registered state)
//   mem_addr_o   : registered memory read address
//   mem_rdata_i  : memory read data, valid the cycle after mem_rd_o
//   sdo_o        : serial data out, MSB first
//   sdo_valid_o  : sdo_o carries a valid bit
//   busy_o       : transfer in progress
//   done_o       : one-cycle pulse after the last bit of the burst
module tt_serial_mem_reader
  import tt_mem_pkg::*;
#(
  parameter int ADDR_W = TT_ADDR_W,
  parameter int DATA_W = TT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] burst_len_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              sdo_o,
  output logic              sdo_valid_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [ADDR_W-1:0] byte_cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              sdo_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              sh_load;
  logic              sh_shift;
  logic              rd;
  logic              last_bit;
  logic              more_bytes;

  assign last_bit   = (bit_cnt_q == '0);
  assign more_bytes = (byte_cnt_q != '0);

  always_comb begin
    state_d  = state_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    rd       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
      end
      FETCH: begin
        rd      = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        sh_load = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Prefetch one cycle ahead so the next byte lands exactly on the
        // last-bit cycle and the stream has no gap.
        if ((bit_cnt_q == CNT_W'(1)) && more_bytes) rd = 1'b1;
        if (last_bit && more_bytes) begin
          sh_load = 1'b1;
        end else begin
          sh_shift = 1'b1;
          if (last_bit) state_d = DONE;
        end
      end
      DONE: begin
        state_d = start_i ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      mem_addr_q  <= '0;
      sdo_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            mem_addr_q <= start_addr_i;
            byte_cnt_q <= burst_len_i;
          end
        end
        LOAD: begin
          bit_cnt_q  <= BIT_LAST;
          mem_addr_q <= mem_addr_q + ADDR_W'(1);
        end
        SHIFT: begin
          if (last_bit && more_bytes) begin
            bit_cnt_q  <= BIT_LAST;
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            byte_cnt_q <= byte_cnt_q - ADDR_W'(1);
          end else if (!last_bit) begin
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
      // Status outputs are registered copies of the state being entered, so
      // they line up with the cycle that state is active.
      sdo_valid_q <= (state_d == SHIFT);
      busy_q      <= (state_d == FETCH) || (state_d == LOAD) || (state_d == SHIFT);
      done_q      <= (state_d == DONE);
    end
  end

  tt_piso_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (mem_rdata_i),
    .msb   (sdo_o)
  );

  assign mem_rd_o    = rd;
  assign mem_addr_o  = mem_addr_q;
  assign sdo_valid_o = sdo_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_tt_serial_mem_reader.sv
module tb_tt_serial_mem_reader;
  import tt_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [5:0] start_addr_i;
  logic [5:0] burst_len_i;
  logic       mem_rd_o;
  logic [5:0] mem_addr_o;
  logic [7:0] mem_rdata_i;
  logic       sdo_o;
  logic       sdo_valid_o;
  logic       busy_o;
  logic       done_o;

  logic [7:0] mem [64];
  logic       exp_bits [$];
  logic [5:0] exp_addr [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         done_seen = 0;
  int         done_exp  = 0;

  always #5 clk = ~clk;

  tt_serial_mem_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .burst_len_i  (burst_len_i),
    .mem_rd_o     (mem_rd_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .sdo_o        (sdo_o),
    .sdo_valid_o  (sdo_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // Synchronous memory model, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: serial bits and read addresses in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sdo_valid_o) begin
        if (exp_bits.size() == 0) chk("extra_bit", 1, 0);
        else chk("sdo_bit", {31'd0, sdo_o}, {31'd0, exp_bits.pop_front()});
      end
      if (mem_rd_o) begin
        if (exp_addr.size() == 0) chk("extra_rd", 1, 0);
        else chk("rd_addr", {26'd0, mem_addr_o}, {26'd0, exp_addr.pop_front()});
      end
      if (done_o) done_seen++;
    end
  end

  task automatic push_exp(input logic [5:0] a, input logic [5:0] l);
    int nbytes;
    logic [5:0] ad;
    logic [7:0] b;
    nbytes = int'(l) + BURST_LEN_OFFSET;
    for (int k = 0; k < nbytes; k++) begin
      ad = a + 6'(k);
      b  = mem[ad];
      exp_addr.push_back(ad);
      for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
    end
  endtask

  // Drive start for one edge; returns at the negedge of the FETCH cycle.
  task automatic kick(input logic [5:0] a, input logic [5:0] l);
    push_exp(a, l);
    @(negedge clk);
    start_i = 1'b1; start_addr_i = a; burst_len_i = l;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Called at the FETCH-cycle negedge; checks latency, contiguity and done.
  task automatic expect_burst(input int nbytes, input int inject_at, input bit chain);
    int cnt;
    cnt = 0;
    chk("fetch_rd", {31'd0, mem_rd_o}, 1);
    chk("fetch_busy", {31'd0, busy_o}, 1);
    chk("fetch_vld", {31'd0, sdo_valid_o}, 0);
    @(negedge clk);
    chk("load_vld", {31'd0, sdo_valid_o}, 0);
    chk("load_rd", {31'd0, mem_rd_o}, 0);
    for (int c = 0; c < 8 * nbytes + 8; c++) begin
      @(negedge clk);
      if (!sdo_valid_o) break;
      cnt++;
      if (cnt == inject_at) begin
        start_i = 1'b1;
        if (chain) begin
          start_addr_i = 6'd7; burst_len_i = 6'd0;
          push_exp(6'd7, 6'd0);
        end else begin
          start_addr_i = 6'd10; burst_len_i = 6'd3;
        end
      end else if (cnt == inject_at + 1 && !chain) begin
        start_i = 1'b0;
      end
    end
    chk("nbits", cnt, 8 * nbytes);
    chk("done_pulse", {31'd0, done_o}, 1);
    chk("done_busy", {31'd0, busy_o}, 0);
    done_exp++;
    if (!chain) begin
      @(negedge clk);
      chk("done_1cyc", {31'd0, done_o}, 0);
      chk("idle_busy", {31'd0, busy_o}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    rst_n = 1'b0; start_i = 1'b0; start_addr_i = '0; burst_len_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {26'd0, mem_rd_o, sdo_o, sdo_valid_o, busy_o, done_o, 1'b0},
        32'd0);
    chk("rst_addr", {26'd0, mem_addr_o}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte
    mem[5] = 8'hA5;
    kick(6'd5, 6'd0);
    expect_burst(1, 0, 1'b0);

    // Gapless burst with address wrap
    mem[62] = 8'h01; mem[63] = 8'h80; mem[0] = 8'hFF;
    kick(6'd62, 6'd2);
    expect_burst(3, 0, 1'b0);

    // Start ignored while busy
    mem[20] = 8'h3C; mem[21] = 8'hC3;
    kick(6'd20, 6'd1);
    expect_burst(2, 5, 1'b0);

    // Back-to-back: start held through DONE
    mem[7] = 8'h96;
    kick(6'd20, 6'd1);
    expect_burst(2, 14, 1'b1);
    @(negedge clk);
    start_i = 1'b0;
    expect_burst(1, 0, 1'b0);

    // Full-length burst
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    kick(6'd0, 6'd63);
    expect_burst(64, 0, 1'b0);

    // Reset mid-SHIFT
    mem[30] = 8'hFF; mem[31] = 8'hFF; mem[32] = 8'hFF; mem[33] = 8'hFF;
    kick(6'd30, 6'd3);
    repeat (12) @(negedge clk);
    chk("pre_rst_vld", {31'd0, sdo_valid_o}, 1);
    #2;
    rst_n = 1'b0;
    exp_bits.delete();
    exp_addr.delete();
    #1;
    chk("arst_outs", {26'd0, mem_rd_o, sdo_o, sdo_valid_o, busy_o, done_o, 1'b0},
        32'd0);
    chk("arst_addr", {26'd0, mem_addr_o}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_o || busy_o || sdo_valid_o || mem_rd_o)
        chk("post_rst_idle", {28'd0, done_o, busy_o, sdo_valid_o, mem_rd_o}, 0);
    end
    chk("post_rst_busy", {31'd0, busy_o}, 0);

    chk("done_count", done_seen, done_exp);
    chk("bits_left", exp_bits.size(), 0);
    chk("addr_left", exp_addr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_serial_mem_reader.md
Name: tt_serial_mem_reader

Overview:
Serial read-out engine for the tile's 64x8 byte memory. This block is the reverse of the existing serial-in capture and write path. On a start command it fetches one or more consecutive bytes through a synchronous, 1-cycle-latency memory read port. It then streams them MSB-first on a single serial pin with a valid strobe, so the host can recover stored bytes one bit per clock.

Parameters:
ADDR_W, 6, memory address width (64 locations)
DATA_W, 8, memory word width and bits shifted per byte

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  start request, sampled on rising clk; ignored while busy_o=1
start_addr_i  in  ADDR_W  first byte address, captured with start_i
burst_len_i  in  ADDR_W  bytes to send minus 1 (0 -> 1 byte, 63 -> 64 bytes), captured with start_i
mem_rd_o  out  1  memory read strobe
mem_addr_o  out  ADDR_W  memory read address (registered)
mem_rdata_i  in  DATA_W  memory read data, valid the cycle after mem_rd_o=1
sdo_o  out  1  serial data out, MSB first
sdo_valid_o  out  1  sdo_o carries a valid bit this cycle
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse after the last bit of the burst

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: mem_addr_o, shift register, bit and byte counters, sdo_o, sdo_valid_o, busy_o, done_o, mem_rd_o. Reset mid-burst aborts immediately, and no done_o is produced.
- States: IDLE, FETCH, LOAD, SHIFT, DONE.
- IDLE:
  - On start_i=1 at an edge, latch start_addr_i into mem_addr_o and burst_len_i into the byte counter, then go to FETCH.
  - busy_o=1 from the next cycle.
- FETCH: mem_rd_o=1 (combinational from state). Go to LOAD.
- LOAD:
  - mem_rdata_i is valid. Load it into the shift register and set bit counter=DATA_W-1.
  - Increment mem_addr_o, wrapping modulo 2^ADDR_W (63 -> 0). Go to SHIFT.
- SHIFT, one bit per cycle:
  - sdo_o = shift register MSB; sdo_valid_o=1. Shift left each cycle and decrement the bit counter.
  - Prefetch: when bit counter==1 and byte counter!=0, mem_rd_o=1 with the current mem_addr_o.
  - When bit counter==0:
    - If byte counter!=0: load mem_rdata_i, reset bit counter, increment mem_addr_o (wrapping), decrement byte counter, stay in SHIFT. The stream has no gap between bytes.
    - If byte counter==0: go to DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0, sdo_valid_o=0. Return to IDLE.
  - start_i is accepted in DONE, behaving as in IDLE, so back-to-back bursts are possible.
- Timing:
  - Latency from start sampled (edge T) to first valid bit: sdo_valid_o rises after edge T+2, i.e. the 3rd cycle after T.
  - Burst of N bytes: exactly 8N consecutive sdo_valid_o cycles.
- sdo_o, sdo_valid_o, busy_o and done_o are registered outputs. mem_rd_o is a combinational decode of registered state only.
- start_i while busy_o=1 (FETCH/LOAD/SHIFT) is ignored and has no effect on the address or counters.
- Memory data is never sampled outside the LOAD cycle and the bit-counter==0 SHIFT cycle.

Decomposition:
- Shared package tt_mem_pkg:
  - ADDR_W/DATA_W defaults, shared with the capture/write path.
  - State enum {IDLE, FETCH, LOAD, SHIFT, DONE}.
  - Burst-length encoding constant (len-1).
- One natural sub-module: tt_piso_shifter (DATA_W parallel-load, MSB-first shift with load/shift enables). The FSM, counters and address logic stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-SHIFT of a preloaded burst -> all outputs 0 on the same cycle rst_n falls; after release, no done_o and state IDLE.
- Single byte: mem[5]=0xA5; start, addr=5, len=0 -> mem_rd_o at T+1 with mem_addr_o=5; sdo bits 1,0,1,0,0,1,0,1 with sdo_valid_o for 8 cycles starting T+3; done_o one pulse; busy_o low afterwards.
- Gapless burst with wrap: mem[62]=0x01, mem[63]=0x80, mem[0]=0xFF; start, addr=62, len=2 -> 24 contiguous valid bits 0x01,0x80,0xFF; mem_addr_o reads 62,63,0.
- Start ignored while busy: assert start_i, addr=10 during SHIFT of a 2-byte burst from 20 -> stream and addresses unchanged (20,21); one done_o only.
- Back-to-back: start_i held high through DONE with addr=7 -> a new burst begins without an IDLE cycle; first bit of mem[7] appears 3 cycles after the DONE edge.
- Full-length burst: len=63, addr=0, mem[i]=i -> 512 valid bits encoding 0..63 in order; done_o after bit 512.
